memboard_top: RTL and testbench

Top level of the memristor-board FPGA. It bridges the Opal Kelly FrontPanel host interface to the board peripherals. Host wire-ins and trigger-ins drive 24-bit serial writes to the bias DAC and to six analog switch banks. They also start dual-channel conversions on the 14-bit simultaneous-sampling ADC, and results are returned on wire-outs. The FrontPanel okHost/endpoint cores are vendor IP instantiated inside this block; all user logic described here runs on CLK.

---
 rtl/memboard_top.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_memboard_top.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/memboard_top.sv
// Memristor-board user logic: FrontPanel endpoints drive a 24-bit serial bus (DAC + six switch
// banks) and a dual-channel 14-bit ADC readout. The ep_* ports carry the okWireIn/okTriggerIn/okWireOut values.
module memboard_top #(
   parameter int CLK_DIV_SPI  = 4,
   parameter int CLK_DIV_ADC  = 8,
   parameter int ADC_BITS     = 14,
   parameter int BUSY_TIMEOUT = 2000
) (
   input  logic        CLK,
   input  logic        RST,
   output logic        CS_DAC,
   output logic        CS_SW1,
   output logic        CS_SW2,
   output logic        CS_SW3,
   output logic        CS_SW4,
   output logic        CS_SW5,
   output logic        CS_SW6,
   output logic        SPI_SCLK,
   output logic        SPI_DIN,
   output logic        CNVST_ADC,
   output logic        CS_ADC,
   output logic        SCLK_ADC,
   input  logic        BUSY_ADC,
   input  logic        DOUTA_ADC,
   input  logic        DOUTB_ADC,
   output logic [7:0]  LED,
   input  logic [7:0]  hi_in,
   output logic [1:0]  hi_out,
   inout  wire  [15:0] hi_inout,
   input  logic        hi_aa,
   output logic        hi_muxsel,
   inout  wire         i2c_sda,
   inout  wire         i2c_scl,
   input  logic [15:0] ep_wi00_i,
   input  logic [15:0] ep_wi01_i,
   input  logic [15:0] ep_wi02_i,
   input  logic [15:0] ep_ti40_i,
   output logic [15:0] ep_wo20_o,
   output logic [15:0] ep_wo21_o,
   output logic [15:0] ep_wo22_o
);
   localparam int SPI_H = CLK_DIV_SPI / 2;
   localparam int ADC_H = CLK_DIV_ADC / 2;

   // SPI: IDLE wait trigger | LOAD latch CS | SHIFT 24 bits | HOLD CS tail + gap
   // ADC: IDLE | CNV pulse | WAIT_HI/WAIT_LO busy handshake | READ 14 bits | DONE latch
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_HOLD} spi_st_e;
   typedef enum logic [2:0] {A_IDLE, A_CNV, A_WAIT_HI, A_WAIT_LO, A_READ, A_DONE} adc_st_e;

   logic rst_any, rst;
   logic [1:0] rst_sync_q;
   assign rst_any = RST | ep_wi00_i[0];
   assign rst     = rst_sync_q[1];

   always_ff @(posedge CLK or posedge rst_any) begin
      if (rst_any) rst_sync_q <= 2'b11;
      else         rst_sync_q <= {rst_sync_q[0], 1'b0};
   end

   spi_st_e spi_st_q, spi_st_d;
   logic [7:0]  spi_div_q, spi_div_d;
   logic [4:0]  spi_bit_q, spi_bit_d;
   logic [23:0] spi_sr_q, spi_sr_d;
   logic [2:0]  spi_tgt_q, spi_tgt_d;
   logic [6:0]  spi_cs_q, spi_cs_d;
   logic        spi_sclk_q, spi_sclk_d, drop_spi_q, drop_spi_d;

   adc_st_e adc_st_q, adc_st_d;
   logic [7:0]  adc_div_q, adc_div_d;
   logic [4:0]  adc_bit_q, adc_bit_d;
   logic [1:0]  adc_cnt_q, adc_cnt_d, busy_sync_q;
   logic [15:0] tmo_q, tmo_d;
   logic [ADC_BITS-1:0] sra_q, sra_d, srb_q, srb_d, res_a_q, res_a_d, res_b_q, res_b_d;
   logic [7:0]  count_q, count_d;
   logic        cs_adc_q, cs_adc_d, sclk_adc_q, sclk_adc_d, cnvst_q;
   logic        valid_q, valid_d, tmo_flag_q, tmo_flag_d, drop_adc_q, drop_adc_d;

   logic trig_spi, trig_adc, spi_busy, adc_busy, busy_s;
   assign trig_spi = ep_ti40_i[0];
   assign trig_adc = ep_ti40_i[1];
   assign spi_busy = (spi_st_q != S_IDLE);
   assign adc_busy = (adc_st_q != A_IDLE);
   assign busy_s   = busy_sync_q[1];

   always_comb begin
      spi_st_d   = spi_st_q;
      spi_div_d  = spi_div_q;
      spi_bit_d  = spi_bit_q;
      spi_sr_d   = spi_sr_q;
      spi_tgt_d  = spi_tgt_q;
      spi_cs_d   = spi_cs_q;
      spi_sclk_d = spi_sclk_q;
      drop_spi_d = drop_spi_q;
      if (trig_spi && spi_busy) drop_spi_d = 1'b1;
      case (spi_st_q)
         S_IDLE: if (trig_spi) begin
            spi_st_d   = S_LOAD;
            spi_sr_d   = {ep_wi02_i[7:0], ep_wi01_i};
            spi_tgt_d  = ep_wi02_i[10:8];
            drop_spi_d = 1'b0;
         end
         S_LOAD: begin
            spi_st_d   = S_SHIFT;
            spi_cs_d   = ~(7'b1 << spi_tgt_q);   // target 7 shifts out: no CS
            spi_div_d  = 8'(SPI_H - 1);
            spi_bit_d  = 5'd23;
            spi_sclk_d = 1'b0;
         end
         S_SHIFT: begin
            if (spi_div_q == 8'd0) begin
               spi_div_d = 8'(SPI_H - 1);
               if (!spi_sclk_q) begin
                  spi_sclk_d = 1'b1;
               end else begin
                  spi_sclk_d = 1'b0;
                  if (spi_bit_q == 5'd0) begin
                     spi_st_d  = S_HOLD;
                     spi_div_d = 8'(3 * SPI_H - 1);
                  end else begin
                     spi_sr_d  = {spi_sr_q[22:0], 1'b0};
                     spi_bit_d = spi_bit_q - 5'd1;
                  end
               end
            end else begin
               spi_div_d = spi_div_q - 8'd1;
            end
         end
         default: begin
            spi_div_d = spi_div_q - 8'd1;
            if (spi_div_q == 8'(2 * SPI_H)) spi_cs_d = '1;
            if (spi_div_q == 8'd0) begin
               spi_st_d  = S_IDLE;
               spi_div_d = 8'd0;
            end
         end
      endcase
   end

   always_comb begin
      adc_st_d   = adc_st_q;
      adc_div_d  = adc_div_q;
      adc_bit_d  = adc_bit_q;
      adc_cnt_d  = adc_cnt_q;
      tmo_d      = tmo_q;
      sra_d      = sra_q;
      srb_d      = srb_q;
      res_a_d    = res_a_q;
      res_b_d    = res_b_q;
      count_d    = count_q;
      cs_adc_d   = cs_adc_q;
      sclk_adc_d = sclk_adc_q;
      valid_d    = valid_q;
      tmo_flag_d = tmo_flag_q;
      drop_adc_d = drop_adc_q;
      if (trig_adc && adc_busy) drop_adc_d = 1'b1;
      case (adc_st_q)
         A_IDLE: if (trig_adc) begin
            adc_st_d   = A_CNV;
            adc_cnt_d  = 2'd3;
            valid_d    = 1'b0;
            tmo_flag_d = 1'b0;
            drop_adc_d = 1'b0;
         end
         A_CNV: begin
            if (adc_cnt_q == 2'd0) begin
               adc_st_d = A_WAIT_HI;
               tmo_d    = 16'(BUSY_TIMEOUT - 1);
            end else begin
               adc_cnt_d = adc_cnt_q - 2'd1;
            end
         end
         A_WAIT_HI, A_WAIT_LO: begin
            tmo_d = tmo_q - 16'd1;
            if (adc_st_q == A_WAIT_HI && busy_s) begin
               adc_st_d = A_WAIT_LO;
            end else if (adc_st_q == A_WAIT_LO && !busy_s) begin
               adc_st_d  = A_READ;
               cs_adc_d  = 1'b0;
               adc_div_d = 8'(ADC_H - 1);
               adc_bit_d = 5'(ADC_BITS);
            end else if (tmo_q == 16'd0) begin
               adc_st_d   = A_IDLE;
               tmo_flag_d = 1'b1;
               valid_d    = 1'b0;
            end
         end
         A_READ: begin
            if (adc_div_q == 8'd0) begin
               adc_div_d = 8'(ADC_H - 1);
               if (sclk_adc_q) begin
                  if (adc_bit_q == 5'd0) adc_st_d = A_DONE;
                  else                   sclk_adc_d = 1'b0;
               end else begin
                  sclk_adc_d = 1'b1;
                  sra_d      = {sra_q[ADC_BITS-2:0], DOUTA_ADC};
                  srb_d      = {srb_q[ADC_BITS-2:0], DOUTB_ADC};
                  adc_bit_d  = adc_bit_q - 5'd1;
               end
            end else begin
               adc_div_d = adc_div_q - 8'd1;
            end
         end
         default: begin
            adc_st_d = A_IDLE;
            cs_adc_d = 1'b1;
            res_a_d  = sra_q;
            res_b_d  = srb_q;
            valid_d  = 1'b1;
            count_d  = count_q + 8'd1;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         spi_st_q    <= S_IDLE;
         spi_div_q   <= '0;
         spi_bit_q   <= '0;
         spi_sr_q    <= '0;
         spi_tgt_q   <= '0;
         spi_cs_q    <= '1;
         spi_sclk_q  <= 1'b0;
         drop_spi_q  <= 1'b0;
         adc_st_q    <= A_IDLE;
         adc_div_q   <= '0;
         adc_bit_q   <= '0;
         adc_cnt_q   <= '0;
         busy_sync_q <= '0;
         tmo_q       <= '0;
         sra_q       <= '0;
         srb_q       <= '0;
         res_a_q     <= '0;
         res_b_q     <= '0;
         count_q     <= '0;
         cs_adc_q    <= 1'b1;
         sclk_adc_q  <= 1'b1;
         cnvst_q     <= 1'b1;
         valid_q     <= 1'b0;
         tmo_flag_q  <= 1'b0;
         drop_adc_q  <= 1'b0;
      end else begin
         spi_st_q    <= spi_st_d;
         spi_div_q   <= spi_div_d;
         spi_bit_q   <= spi_bit_d;
         spi_sr_q    <= spi_sr_d;
         spi_tgt_q   <= spi_tgt_d;
         spi_cs_q    <= spi_cs_d;
         spi_sclk_q  <= spi_sclk_d;
         drop_spi_q  <= drop_spi_d;
         adc_st_q    <= adc_st_d;
         adc_div_q   <= adc_div_d;
         adc_bit_q   <= adc_bit_d;
         adc_cnt_q   <= adc_cnt_d;
         busy_sync_q <= {busy_sync_q[0], BUSY_ADC};
         tmo_q       <= tmo_d;
         sra_q       <= sra_d;
         srb_q       <= srb_d;
         res_a_q     <= res_a_d;
         res_b_q     <= res_b_d;
         count_q     <= count_d;
         cs_adc_q    <= cs_adc_d;
         sclk_adc_q  <= sclk_adc_d;
         cnvst_q     <= (adc_st_q != A_CNV);
         valid_q     <= valid_d;
         tmo_flag_q  <= tmo_flag_d;
         drop_adc_q  <= drop_adc_d;
      end
   end

   assign {CS_SW6, CS_SW5, CS_SW4, CS_SW3, CS_SW2, CS_SW1, CS_DAC} = spi_cs_q;
   assign SPI_SCLK  = spi_sclk_q;
   assign SPI_DIN   = spi_sr_q[23] & (spi_st_q == S_SHIFT);
   assign CNVST_ADC = cnvst_q;
   assign CS_ADC    = cs_adc_q;
   assign SCLK_ADC  = sclk_adc_q;
   assign LED       = ~{count_q[5:0], adc_busy, spi_busy};
   assign ep_wo20_o = {count_q, 3'b000, drop_spi_q | drop_adc_q, tmo_flag_q, valid_q, adc_busy, spi_busy};
   assign ep_wo21_o = {{(16 - ADC_BITS){1'b0}}, res_a_q};
   assign ep_wo22_o = {{(16 - ADC_BITS){1'b0}}, res_b_q};

   // Host bus pins belong to okHost; this block only ties off what it owns.
   assign hi_out    = 2'b00;
   assign hi_muxsel = 1'b0;
   assign hi_inout  = 16'bz;
   assign i2c_sda   = 1'bz;
   assign i2c_scl   = 1'bz;

   logic unused_host;
   assign unused_host = ^{hi_in, hi_aa, hi_inout, i2c_sda, i2c_scl,
                          ep_wi00_i[15:1], ep_wi02_i[15:11], ep_ti40_i[15:2]};
endmodule

// File: tb/tb_memboard_top.sv
// Directed bench for memboard_top: serial frames, ADC readout with a BUSY/DOUT model,
// timeout, overlap/drop and asynchronous reset mid-frame.
module tb_memboard_top;
   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic RST;
   logic [15:0] wi00, wi01, wi02, ti40;
   wire  [15:0] wo20, wo21, wo22;
   logic BUSY_ADC = 1'b0, DOUTA_ADC = 1'b0, DOUTB_ADC = 1'b0;
   wire  CS_DAC, CS_SW1, CS_SW2, CS_SW3, CS_SW4, CS_SW5, CS_SW6;
   wire  SPI_SCLK, SPI_DIN, CNVST_ADC, CS_ADC, SCLK_ADC;
   wire  [7:0] LED;
   logic [7:0] hi_in = 8'h00;
   logic hi_aa = 1'b0;
   wire  [1:0] hi_out;
   wire  [15:0] hi_inout;
   wire  hi_muxsel, i2c_sda, i2c_scl;

   memboard_top dut (
      .CLK(CLK), .RST(RST), .CS_DAC(CS_DAC), .CS_SW1(CS_SW1), .CS_SW2(CS_SW2),
      .CS_SW3(CS_SW3), .CS_SW4(CS_SW4), .CS_SW5(CS_SW5), .CS_SW6(CS_SW6),
      .SPI_SCLK(SPI_SCLK), .SPI_DIN(SPI_DIN), .CNVST_ADC(CNVST_ADC), .CS_ADC(CS_ADC),
      .SCLK_ADC(SCLK_ADC), .BUSY_ADC(BUSY_ADC), .DOUTA_ADC(DOUTA_ADC), .DOUTB_ADC(DOUTB_ADC),
      .LED(LED), .hi_in(hi_in), .hi_out(hi_out), .hi_inout(hi_inout), .hi_aa(hi_aa),
      .hi_muxsel(hi_muxsel), .i2c_sda(i2c_sda), .i2c_scl(i2c_scl),
      .ep_wi00_i(wi00), .ep_wi01_i(wi01), .ep_wi02_i(wi02), .ep_ti40_i(ti40),
      .ep_wo20_o(wo20), .ep_wo21_o(wo21), .ep_wo22_o(wo22)
   );

   wire [6:0] cs_all = {CS_SW6, CS_SW5, CS_SW4, CS_SW3, CS_SW2, CS_SW1, CS_DAC};
   int cs_low [7];
   int cs_adc_low = 0;
   int spi_rises = 0;
   logic [23:0] spi_cap = 24'h0;

   always @(negedge CLK) begin
      for (int i = 0; i < 7; i++) if (!cs_all[i]) cs_low[i] = cs_low[i] + 1;
      if (!CS_ADC) cs_adc_low = cs_adc_low + 1;
   end

   always @(posedge SPI_SCLK) begin
      spi_rises = spi_rises + 1;
      spi_cap   = {spi_cap[22:0], SPI_DIN};
   end

   logic model_en = 1'b0;
   logic [13:0] word_a = 14'h0, word_b = 14'h0;

   always @(negedge CNVST_ADC) if (model_en) begin
      #40 BUSY_ADC = 1'b1;
      #700 BUSY_ADC = 1'b0;
   end

   always @(negedge CS_ADC) begin
      for (int k = 13; k >= 0; k--) begin
         @(negedge SCLK_ADC);
         #20;
         DOUTA_ADC = word_a[k];
         DOUTB_ADC = word_b[k];
      end
   end

   int n_assert = 0, n_fail = 0;
   int cs0 [7];
   int r0, a0, n;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic [15:0] bits);
      @(posedge CLK); #1 ti40 = bits;
      @(posedge CLK); #1 ti40 = 16'h0;
   endtask

   task automatic snap();
      r0 = spi_rises;
      for (int i = 0; i < 7; i++) cs0[i] = cs_low[i];
   endtask

   task automatic check_frame(input int sel, input logic [23:0] data);
      check("spi_rises", spi_rises - r0, 24);
      check("spi_data", {8'h0, spi_cap}, {8'h0, data});
      for (int i = 0; i < 7; i++)
         check($sformatf("cs%0d_low_cycles", i), cs_low[i] - cs0[i], (i == sel) ? 98 : 0);
   endtask

   task automatic wait_clear(input int bitn, input int maxc, input string tag);
      int c = 0;
      while (wo20[bitn] && c < maxc) begin
         @(negedge CLK);
         c++;
      end
      check(tag, {31'h0, wo20[bitn]}, 0);
   endtask

   initial begin
      RST = 1'b1; wi00 = 16'h0; wi01 = 16'h0; wi02 = 16'h0; ti40 = 16'h0;
      repeat (3) @(negedge CLK);
      check("rst_cs", {25'h0, cs_all}, 32'h7F);
      check("rst_cnvst", CNVST_ADC, 1);
      check("rst_sclk_adc", SCLK_ADC, 1);
      check("rst_spi_sclk", SPI_SCLK, 0);
      check("rst_spi_din", SPI_DIN, 0);
      check("rst_led", LED, 8'hFF);
      check("rst_status", wo20, 0);
      RST = 1'b0;
      repeat (4) @(negedge CLK);

      wi01 = 16'hC30F; wi02 = 16'h03A5; snap();
      pulse(16'h1);
      check("cs_sw3_lat1", CS_SW3, 1);
      check("spi_busy_set", wo20[0], 1);
      @(posedge CLK); #1 check("cs_sw3_lat2", CS_SW3, 0);
      wait_clear(0, 200, "spi_done_sw3");
      check_frame(3, 24'hA5C30F);

      wi01 = 16'h1234; wi02 = 16'h07FF; snap();
      pulse(16'h1);
      wait_clear(0, 200, "spi_done_t7");
      check_frame(7, 24'hFF1234);

      word_a = 14'h2ABC; word_b = 14'h1357; model_en = 1'b1;
      pulse(16'h2);
      check("cnvst_lat1", CNVST_ADC, 1);
      check("adc_busy_set", wo20[1], 1);
      @(posedge CLK); #1 check("cnvst_lat2", CNVST_ADC, 0);
      wait_clear(1, 400, "adc_done1");
      check("adc1_a", wo21, 16'h2ABC);
      check("adc1_b", wo22, 16'h1357);
      check("adc1_status", wo20, 16'h0104);
      check("adc1_led", LED, 8'hFB);

      word_a = 14'h3001; word_b = 14'h0003;
      pulse(16'h2);
      n = 0;
      while (CS_ADC && n < 200) begin @(negedge CLK); n++; end
      check("adc2_read_start", CS_ADC, 0);
      repeat (20) @(negedge CLK);
      wi01 = 16'h0001; wi02 = 16'h005A; snap();
      pulse(16'h3);
      check("adc_drop_set", wo20[4], 1);
      wait_clear(1, 400, "adc_done2");
      wait_clear(0, 200, "spi_done_dac");
      check("adc2_a", wo21, 16'h3001);
      check("adc2_b", wo22, 16'h0003);
      check("adc2_status", wo20, 16'h0214);
      check_frame(0, 24'h5A0001);

      model_en = 1'b0; a0 = cs_adc_low;
      pulse(16'h2);
      repeat (2003) @(posedge CLK);
      #1 check("tmo_still_busy", wo20[1], 1);
      @(posedge CLK); #1 check("tmo_idle", wo20[1], 0);
      check("tmo_status", wo20, 16'h0208);
      check("tmo_result_kept", wo21, 16'h3001);
      check("tmo_cs_adc_quiet", cs_adc_low - a0, 0);
      check("tmo_led", LED, 8'hF7);

      wi01 = 16'h3456; wi02 = 16'h0012; snap();
      pulse(16'h1);
      n = 0;
      while ((spi_rises - r0) < 10 && n < 200) begin @(negedge CLK); n++; end
      check("mid_reached_bit10", spi_rises - r0, 10);
      #3 RST = 1'b1;
      #1 check("mid_cs_dac", CS_DAC, 1);
      check("mid_spi_sclk", SPI_SCLK, 0);
      check("mid_led", LED, 8'hFF);
      check("mid_status", wo20, 0);
      check("mid_result", wo21, 0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      repeat (4) @(negedge CLK);
      wi01 = 16'hDCBA; wi02 = 16'h00FE; snap();
      pulse(16'h1);
      wait_clear(0, 200, "spi_done_after_rst");
      check_frame(0, 24'hFEDCBA);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
